fft_in_framer: RTL and testbench
================================

# fft_in_framer

Input framing stage placed directly upstream of `dit_fft_8`. Accepts a serial stream of complex Q4.12 samples under a valid/ready handshake and assembles 8-sample frames in a ping-pong buffer. Presents each frame as a held, parallel word to the transform core, together with that frame's FFT/IFFT mode bit. Supports short frames, which are zero-padded, and optional bit-reversed placement.

## Interface
- `DW`, 16: sample component width, signed Q4.12.
- `N`, 8: frame length. Fixed at 8 for this release.
- `BITREV`, 0: 1 = sample k is stored at index bitrev3(k); 0 = natural order.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: framer can accept a sample.
- `in_re`, `in_im` in DW each: signed sample components.
- `in_last` in 1: closes the frame early; only meaningful with `in_valid`.
- `mode_in` in 1: 1 = IFFT. Sampled with the first sample of each frame.
- `frame_valid` out 1: `x_re`/`x_im` hold a complete frame.
- `frame_ready` in 1: consumer takes the frame.
- `x_re`, `x_im` out N*DW each: element i at bits [i*DW +: DW].
- `frame_mode` out 1: mode of the presented frame.
- `frame_len` out 4: count of real samples in the presented frame, 1..8.

## Operation
- Storage: two banks (A, B), each N x 2 x DW. Per-bank state is EMPTY, FILLING or FULL. A write-bank pointer `wb` and a read-bank pointer `rb` both start at A.
- Transfer: a sample is accepted when `in_valid && in_ready`.
- Write index: a 3-bit counter `wcnt`. The sample goes to index `wcnt`, or to bitrev3(`wcnt`) when BITREV=1.
- First sample of a frame (`wcnt`=0):
  - clears the whole bank to zero first, then writes the sample,
  - latches `mode_in` into the bank's mode tag,
  - moves the bank to FILLING.
- Frame close: the frame closes on the 8th sample, or on any sample carrying `in_last`. On close:
  - the bank goes to FULL,
  - its length tag is set to `wcnt`+1,
  - `wcnt` resets to 0,
  - `wb` toggles.
- `in_last` on the 8th sample behaves the same as a normal close.
- `in_ready` = (bank[`wb`] != FULL), combinational from state only. It has no dependence on `in_valid`.
- Output register stage:
  - Loads when bank[`rb`] is FULL and (`frame_valid`==0 or `frame_ready`==1).
  - A load copies data, mode tag and length tag into `x_re`/`x_im`/`frame_mode`/`frame_len`, sets bank[`rb`] to EMPTY, toggles `rb`, and sets `frame_valid`.
  - If `frame_valid && frame_ready` and no bank is FULL, `frame_valid` clears. `x_*` keep their last values, because the FFT core reads them continuously.
- Simultaneous events:
  - A closing write to bank X and a load from bank Y≠X in the same cycle both take effect.
  - A load never reads a bank that is still FILLING.
  - A bank freed by a load is writable from the next cycle.

## Timing
- Reset (`reset`=0), asynchronous: `x_re`=`x_im`=0, `frame_valid`=0, `frame_mode`=0, `frame_len`=0, `wcnt`=0, both banks EMPTY, `wb`=`rb`=A. `in_ready`=1 while reset is held.
- Reset asserted mid-frame discards all partial and full frames. No frame is emitted for the discarded data.
- Latency: last sample accepted at edge E gives `frame_valid`=1 and new `x_*` after edge E+1, provided the output stage is free.
- Throughput: with `frame_ready` held at 1, one frame per N accepted samples and `in_ready` never deasserts.
- Backpressure: with the output register plus both banks full, `in_ready`=0. It returns to 1 the cycle after the load edge that frees a bank.
- Output stability: `x_*` change only on a load edge. They are stable for at least 1 cycle, and for 8 cycles at full rate. This covers the 3-cycle latency of the FFT core.

## Test plan
- Reset mid-frame: 5 samples accepted, `reset`=0 for 1 cycle, then 8 samples (k*16'h1000) -> no frame from the first 5; a single frame with `x_re` element i = i*16'h1000 and `frame_len`=8.
- Nominal: samples re=k*16'h1000, im=-re for k=0..7, `mode_in`=1, `frame_ready`=1 -> `frame_valid` rises the edge after sample 7; element 3 = (16'h3000, 16'hD000); `frame_mode`=1.
- Short frame: 3 samples (16'h1000, 16'h2000, 16'h3000) with `in_last` on the third -> elements 3..7 = 0 and `frame_len`=3. A following full frame is unaffected.
- Backpressure: `frame_ready`=0, 24 samples streamed continuously:
  - `in_ready` drops right after the 24th accept,
  - one cycle of `frame_ready`=1 -> frame 2 is presented and `in_ready` returns next cycle,
  - no sample is lost or duplicated.
- BITREV=1: input values 0..7 (re) -> `x_re` elements = 0,4,2,6,1,5,3,7.
- Mode latch: `mode_in` toggles from 0 to 1 at sample 4 -> `frame_mode`=0. The next frame started with `mode_in`=1 gives `frame_mode`=1.

Source files
------------

// File: rtl/fft_in_framer_if.sv
// Sample-stream and frame-output signals of the FFT input framer.
// The master side drives samples and consumes frames; the slave side is the framer.
interface fft_in_framer_if #(
  parameter int DW = 16,
  parameter int N  = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_re;
  logic [DW-1:0]   in_im;
  logic            in_last;
  logic            mode_in;
  logic            frame_valid;
  logic            frame_ready;
  logic [N*DW-1:0] x_re;
  logic [N*DW-1:0] x_im;
  logic            frame_mode;
  logic [3:0]      frame_len;

  modport master (
    output in_valid, in_re, in_im, in_last, mode_in, frame_ready,
    input  in_ready, frame_valid, x_re, x_im, frame_mode, frame_len
  );

  modport slave (
    input  in_valid, in_re, in_im, in_last, mode_in, frame_ready,
    output in_ready, frame_valid, x_re, x_im, frame_mode, frame_len
  );
endinterface

// File: rtl/fft_in_framer.sv
// Ping-pong framer: packs a serial complex stream into 8-sample frames (zero-padded
// when closed early) and holds each frame as a parallel word for the FFT core.
module fft_in_framer #(
  parameter int DW     = 16,
  parameter int N      = 8,
  parameter bit BITREV = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  fft_in_framer_if.slave bus
);
  typedef enum logic [1:0] {BK_EMPTY, BK_FILLING, BK_FULL} bank_e;

  localparam logic [2:0] WLAST = 3'(N - 1);

  bank_e         bst_q [2];
  bank_e         bst_d [2];
  logic          wb_q, wb_d, rb_q, rb_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic          fv_q, fv_d;

  logic [DW-1:0] bre_q [2][N];
  logic [DW-1:0] bim_q [2][N];
  logic          mode_q [2];
  logic [3:0]    len_q [2];

  logic [N*DW-1:0] xre_q, xim_q;
  logic            fmode_q;
  logic [3:0]      flen_q;

  logic          in_ready, accept, first, close, load;
  logic [2:0]    widx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bst_q[0] <= BK_EMPTY;
      bst_q[1] <= BK_EMPTY;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      wcnt_q   <= '0;
      fv_q     <= 1'b0;
    end else begin
      bst_q  <= bst_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wcnt_q <= wcnt_d;
      fv_q   <= fv_d;
    end
  end

  // Write and load never target the same bank: load needs FULL, write needs not-FULL.
  always_comb begin
    bst_d  = bst_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    wcnt_d = wcnt_q;
    fv_d   = fv_q;
    if (accept) begin
      bst_d[wb_q] = close ? BK_FULL : BK_FILLING;
      wcnt_d      = close ? 3'd0 : wcnt_q + 3'd1;
      wb_d        = close ? ~wb_q : wb_q;
    end
    if (load) begin
      bst_d[rb_q] = BK_EMPTY;
      rb_d        = ~rb_q;
      fv_d        = 1'b1;
    end else if (fv_q && bus.frame_ready) begin
      fv_d = 1'b0;
    end
  end

  always_comb begin
    in_ready = (bst_q[wb_q] != BK_FULL);
    accept   = bus.in_valid && in_ready;
    first    = accept && (wcnt_q == 3'd0);
    close    = accept && ((wcnt_q == WLAST) || bus.in_last);
    load     = (bst_q[rb_q] == BK_FULL) && (!fv_q || bus.frame_ready);
    widx     = BITREV ? {wcnt_q[0], wcnt_q[1], wcnt_q[2]} : wcnt_q;
  end

  // The sample write follows the clear so it wins for its own index.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (first) begin
        for (int unsigned i = 0; i < N; i++) begin
          bre_q[wb_q][i] <= '0;
          bim_q[wb_q][i] <= '0;
        end
        mode_q[wb_q] <= bus.mode_in;
      end
      bre_q[wb_q][widx] <= bus.in_re;
      bim_q[wb_q][widx] <= bus.in_im;
      if (close) len_q[wb_q] <= 4'(wcnt_q) + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xre_q   <= '0;
      xim_q   <= '0;
      fmode_q <= 1'b0;
      flen_q  <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < N; i++) begin
        xre_q[i*DW +: DW] <= bre_q[rb_q][i];
        xim_q[i*DW +: DW] <= bim_q[rb_q][i];
      end
      fmode_q <= mode_q[rb_q];
      flen_q  <= len_q[rb_q];
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.frame_valid = fv_q;
  assign bus.x_re        = xre_q;
  assign bus.x_im        = xim_q;
  assign bus.frame_mode  = fmode_q;
  assign bus.frame_len   = flen_q;
endmodule

// File: tb/tb_fft_in_framer.sv
// Directed bench for fft_in_framer with a frame scoreboard; a second instance
// (BITREV=1) is selected through sel for the bit-reversed placement case.
module tb_fft_in_framer;
  localparam int DW = 16;
  localparam int N  = 8;

  typedef struct packed {
    logic [N*DW-1:0] re;
    logic [N*DW-1:0] im;
    logic            mode;
    logic [3:0]      len;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft_in_framer_if #(.DW(DW), .N(N)) b0 ();
  fft_in_framer_if #(.DW(DW), .N(N)) b1 ();

  fft_in_framer #(.DW(DW), .N(N), .BITREV(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  fft_in_framer #(.DW(DW), .N(N), .BITREV(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  logic          sel = 1'b0, vld = 1'b0, last = 1'b0, mode = 1'b0, fr = 1'b1;
  logic [DW-1:0] dre = '0, dim = '0;

  assign b0.in_valid = vld && !sel;
  assign b1.in_valid = vld && sel;
  assign b0.in_re = dre;   assign b1.in_re = dre;
  assign b0.in_im = dim;   assign b1.in_im = dim;
  assign b0.in_last = last; assign b1.in_last = last;
  assign b0.mode_in = mode; assign b1.mode_in = mode;
  assign b0.frame_ready = fr; assign b1.frame_ready = fr;

  logic            rdy, fv, fmode;
  logic [N*DW-1:0] xre, xim;
  logic [3:0]      flen;
  assign rdy   = sel ? b1.in_ready    : b0.in_ready;
  assign fv    = sel ? b1.frame_valid : b0.frame_valid;
  assign xre   = sel ? b1.x_re        : b0.x_re;
  assign xim   = sel ? b1.x_im        : b0.x_im;
  assign fmode = sel ? b1.frame_mode  : b0.frame_mode;
  assign flen  = sel ? b1.frame_len   : b0.frame_len;

  int     total = 0, passed = 0, nframes = 0, stalls = 0, mcnt = 0;
  frame_t q[$];
  frame_t cur;

  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_accept(input logic [DW-1:0] r, input logic [DW-1:0] i,
                              input logic m, input logic l);
    logic [2:0] k;
    logic [2:0] idx;
    if (mcnt == 0) begin
      cur = '0;
      cur.mode = m;
    end
    k = 3'(mcnt);
    idx = sel ? {k[0], k[1], k[2]} : k;
    cur.re[idx*DW +: DW] = r;
    cur.im[idx*DW +: DW] = i;
    mcnt++;
    if (mcnt == N || l) begin
      cur.len = 4'(mcnt);
      q.push_back(cur);
      mcnt = 0;
    end
  endtask

  task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] i,
                      input logic m, input logic l);
    bit acc;
    int n = 0;
    dre = r; dim = i; mode = m; last = l; vld = 1'b1;
    do begin
      acc = rdy;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    vld = 1'b0; last = 1'b0;
    stalls += n - 1;
    if (acc) model_accept(r, i, m, l);
    else chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // A frame is new when it appears after an edge at which the output stage was free.
  bit pfree = 1'b1;
  always @(negedge clk) begin
    frame_t e;
    if (!reset) pfree = 1'b1;
    else begin
      if (fv && pfree) begin
        if (q.size() == 0) chk("unexpected_frame", 1'b1, 1'b0);
        else begin
          e = q.pop_front();
          chk("sb_x_re", xre, e.re);
          chk("sb_x_im", xim, e.im);
          chk("sb_mode", fmode, e.mode);
          chk("sb_len", flen, e.len);
          nframes++;
        end
      end
      pfree = !fv || fr;
    end
  end

  initial begin
    logic [N*DW-1:0] tmp;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fv", fv, 1'b0);
    chk("rst_xre", xre, '0);
    chk("rst_xim", xim, '0);
    chk("rst_len", flen, 4'd0);
    chk("rst_mode", fmode, 1'b0);
    chk("rst_rdy", rdy, 1'b1);
    reset = 1'b1;
    idle(2);

    // reset mid-frame: partial data must vanish
    for (int k = 0; k < 5; k++) send(16'(k * 16'h0111 + 5), 16'(k), 1'b0, 1'b0);
    reset = 1'b0;
    mcnt = 0;
    @(posedge clk); #1;
    chk("midrst_rdy", rdy, 1'b1);
    chk("midrst_fv", fv, 1'b0);
    reset = 1'b1;
    idle(1);
    for (int k = 0; k < 8; k++) send(16'(k * 16'h1000), 16'(k + 1), 1'b0, 1'b0);
    idle(4);
    chk("midrst_e5", xre[5*DW +: DW], 16'h5000);
    chk("midrst_len", flen, 4'd8);
    chk("midrst_nframes", nframes, 1);

    // nominal with latency check
    for (int k = 0; k < 8; k++) send(16'(k * 16'h1000), 16'(-(k * 16'h1000)), 1'b1, 1'b0);
    chk("lat_pre", fv, 1'b0);
    @(posedge clk); #1;
    chk("lat_post", fv, 1'b1);
    chk("nom_e3_re", xre[3*DW +: DW], 16'h3000);
    chk("nom_e3_im", xim[3*DW +: DW], 16'hD000);
    chk("nom_mode", fmode, 1'b1);
    idle(3);

    // short frame then a full frame
    send(16'h1000, 16'h0001, 1'b0, 1'b0);
    send(16'h2000, 16'h0002, 1'b0, 1'b0);
    send(16'h3000, 16'h0003, 1'b0, 1'b1);
    idle(3);
    tmp = xre >> (3 * DW);
    chk("short_pad_re", tmp, '0);
    tmp = xim >> (3 * DW);
    chk("short_pad_im", tmp, '0);
    chk("short_len", flen, 4'd3);
    for (int k = 0; k < 8; k++) send(16'(k * 16'h0100 + 7), 16'(k * 3), 1'b0, 1'b0);
    idle(3);

    // mode latched on first sample only
    for (int k = 0; k < 8; k++) send(16'(k + 16'h0040), 16'(k), (k >= 4), 1'b0);
    idle(3);
    chk("mode_latch", fmode, 1'b0);
    for (int k = 0; k < 8; k++) send(16'(k + 16'h0080), 16'(k), 1'b1, 1'b0);
    idle(3);
    chk("mode_next", fmode, 1'b1);

    // backpressure: 24 samples with consumer stalled
    fr = 1'b0;
    stalls = 0;
    for (int k = 0; k < 24; k++) send(16'(k * 3 + 1), 16'(~k), 1'b0, 1'b0);
    chk("bp_nostall", stalls, 0);
    chk("bp_rdy_low", rdy, 1'b0);
    idle(2);
    chk("bp_rdy_hold", rdy, 1'b0);
    chk("bp_fv_hold", fv, 1'b1);
    fr = 1'b1;
    @(posedge clk); #1;
    fr = 1'b0;
    chk("bp_rdy_back", rdy, 1'b1);
    chk("bp_f2_e0", xre[0 +: DW], 16'd25);
    idle(2);
    fr = 1'b1;
    idle(4);

    // bit-reversed placement on the second instance
    sel = 1'b1;
    idle(1);
    for (int k = 0; k < 8; k++) send(16'(k), 16'h0000, 1'b0, 1'b0);
    idle(4);
    chk("bitrev_xre", xre, {16'd7, 16'd3, 16'd5, 16'd1, 16'd6, 16'd2, 16'd4, 16'd0});
    sel = 1'b0;
    idle(2);

    chk("sb_empty", q.size(), 0);
    chk("frames_total", nframes, 10);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
